fm_demodulator: RTL and testbench

Receive-side counterpart of the FM transmitter. Takes a 1-bit FM/IF square wave (comparator output), synchronises it, counts rising edges over a fixed gate window and converts the count deviation from centre into an 8-bit offset-binary sample. Output bytes use the same format as the UART byte stream feeding the transmitter (signed sample + 128), so they drive a UART transmitter directly. Includes a carrier-lock detector that mutes output while unlocked.

---
 rtl/fm_demodulator_pkg.sv | 28 ++
 rtl/fm_demodulator_lock.sv | 83 ++++++++
 rtl/fm_demodulator.sv | 199 +++++++++++++++++++
 tb/tb_fm_demodulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_demodulator_pkg.sv
// -----------------------------------------------------------------------------
// fm_demodulator_pkg
// Shared definitions for the FM receive path: the mute code, the offset-binary
// bias used on the byte stream, and the lock-detector state encoding.
// The transmitter top uses the same encodings, so keep them in step.
// No ports (package).
// -----------------------------------------------------------------------------
package fm_demodulator_pkg;

    // Output byte for "zero deviation" and for a muted (unlocked) receiver.
    localparam logic [7:0] MUTE_CODE = 8'h80;

    // Offset-binary bias: byte = signed sample + OFFSET.
    localparam int OFFSET = 128;

    // Carrier lock detector states.
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Signed 8-bit sample to offset binary. Adding 128 modulo 256 is the same
    // as flipping the sign bit.
    function automatic logic [7:0] to_offset_binary(input logic signed [7:0] sample);
        return sample ^ MUTE_CODE;
    endfunction

endpackage

// File: rtl/fm_demodulator_lock.sv
// -----------------------------------------------------------------------------
// fm_lock_detect
// Carrier lock detector. Each measurement window delivers one in-range flag.
// In SEARCH, LOCK_WINDOWS consecutive in-range windows declare lock; in
// LOCKED, LOCK_WINDOWS consecutive out-of-range windows drop it. Any window
// that breaks a streak clears the streak counter.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_vld       one-cycle strobe, i_in_range is valid
//   i_in_range  |deviation| of the closing window is within tolerance
//   o_locked    registered lock status (high while in LOCKED)
// -----------------------------------------------------------------------------
module fm_lock_detect
    import fm_demodulator_pkg::*;
#(
    parameter int LOCK_WINDOWS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    input  logic i_in_range,
    output logic o_locked
);

    localparam int RW = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS + 1) : 1;
    localparam logic [RW-1:0] LAST_STEP = RW'(LOCK_WINDOWS - 1);

    lock_state_e   state_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] miss_q;
    logic          locked_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
        end else if (i_vld) begin
            case (state_q)
                SEARCH: begin
                    if (i_in_range) begin
                        // The window completing the streak switches state now,
                        // so it is emitted with the new lock status.
                        if (run_q == LAST_STEP) begin
                            state_q  <= LOCKED;
                            run_q    <= '0;
                            locked_q <= 1'b1;
                        end else begin
                            run_q <= run_q + RW'(1);
                        end
                    end else begin
                        run_q <= '0;
                    end
                end
                LOCKED: begin
                    if (!i_in_range) begin
                        if (miss_q == LAST_STEP) begin
                            state_q  <= SEARCH;
                            miss_q   <= '0;
                            locked_q <= 1'b0;
                        end else begin
                            miss_q <= miss_q + RW'(1);
                        end
                    end else begin
                        miss_q <= '0;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    run_q    <= '0;
                    miss_q   <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_locked = locked_q;

endmodule

// File: rtl/fm_demodulator.sv
// -----------------------------------------------------------------------------
// fm_demodulator
// Counting FM discriminator. The 1-bit IF square wave is synchronised, its
// rising edges are counted over a fixed gate window, and the count deviation
// from the centre count becomes an 8-bit offset-binary sample (0x80 = centre),
// the same byte format that feeds the FM transmitter. Output is muted to 0x80
// while the carrier lock detector reports no lock.
//
// Pipeline (relative to the clock edge that closes a window):
//   edge 0 : capture edge count (including a rise in the closing cycle)
//   edge +1: deviation registered, lock detector updated
//   edge +2: sample, clip flag, lock status and strobe registered
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_rf       asynchronous FM/IF square wave
//   o_dat      demodulated sample, offset binary
//   o_dat_vld  one-cycle strobe, o_dat/o_clip valid
//   o_clip     deviation saturated in this sample (qualified by o_dat_vld)
//   o_locked   carrier lock status
// -----------------------------------------------------------------------------
module fm_demodulator
    import fm_demodulator_pkg::*;
#(
    parameter int GATE_CYCLES  = 25000,
    parameter int CENTER_COUNT = 1070,
    parameter int SHIFT        = 0,
    parameter int CNT_W        = 16,
    parameter int LOCK_TOL     = 16,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rf,
    output logic [7:0] o_dat,
    output logic       o_dat_vld,
    output logic       o_clip,
    output logic       o_locked
);

    localparam int GW     = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DIFF_W = CNT_W + 1;

    localparam logic [GW-1:0]            GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic signed [DIFF_W-1:0] CENTER    = DIFF_W'(CENTER_COUNT);

    // ------------------------------------------------------------------
    // Input synchroniser plus one delay stage for rising-edge detection
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= i_rf;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;

    // ------------------------------------------------------------------
    // Gate and edge counters
    // ------------------------------------------------------------------
    logic [GW-1:0]    gate_q,   gate_d;
    logic [CNT_W-1:0] ecnt_q,   ecnt_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             cap_vld_q, cap_vld_d;
    logic [CNT_W-1:0] ecnt_inc;
    logic             win_end;

    always_comb begin
        win_end = (gate_q == GATE_LAST);
        gate_d  = win_end ? '0 : gate_q + GW'(1);

        // Saturate instead of wrapping so an overdriven input reads as a
        // large positive deviation rather than an aliased small one.
        ecnt_inc = (rise && (ecnt_q != '1)) ? ecnt_q + CNT_W'(1) : ecnt_q;

        // A rise in the closing cycle belongs to the closing window.
        ecnt_d    = win_end ? '0 : ecnt_inc;
        cnt_d     = win_end ? ecnt_inc : cnt_q;
        cap_vld_d = win_end;
    end

    // ------------------------------------------------------------------
    // Stage 1: deviation from centre and in-range decision
    // ------------------------------------------------------------------
    logic signed [DIFF_W-1:0] diff_q, diff_d;
    logic signed [31:0]       diff_d_ext;
    logic                     in_range;
    logic                     st1_vld_q, st1_vld_d;

    always_comb begin
        diff_d     = $signed({1'b0, cnt_q}) - CENTER;
        diff_d_ext = 32'(diff_d);
        // Two-sided compare avoids the overflow of abs() at the most
        // negative deviation.
        in_range   = (diff_d_ext <= LOCK_TOL) && (diff_d_ext >= -LOCK_TOL);
        st1_vld_d  = cap_vld_q;
    end

    logic det_locked;

    fm_lock_detect #(
        .LOCK_WINDOWS (LOCK_WINDOWS)
    ) u_lock (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_vld      (cap_vld_q),
        .i_in_range (in_range),
        .o_locked   (det_locked)
    );

    // ------------------------------------------------------------------
    // Stage 2: scale, saturate, mute and strobe
    // ------------------------------------------------------------------
    logic [7:0]         dat_q,    dat_d;
    logic               vld_q,    vld_d;
    logic               clip_q,   clip_d;
    logic               locked_q, locked_d;
    logic signed [31:0] diff_q_ext;
    logic signed [31:0] shifted;
    logic [7:0]         sat_sample;
    logic               sat_clip;

    always_comb begin
        diff_q_ext = 32'(diff_q);
        shifted    = diff_q_ext >>> SHIFT;

        sat_clip   = 1'b0;
        sat_sample = shifted[7:0];
        if (shifted > 32'sd127) begin
            sat_clip   = 1'b1;
            sat_sample = 8'h7F;
        end else if (shifted < -32'sd128) begin
            sat_clip   = 1'b1;
            sat_sample = 8'h80;
        end

        dat_d    = dat_q;
        clip_d   = clip_q;
        locked_d = locked_q;
        vld_d    = st1_vld_q;
        if (st1_vld_q) begin
            // Lock state was updated one edge earlier, so the window that
            // flips it is already muted/unmuted here. Clip is reported
            // even when muted.
            dat_d    = det_locked ? to_offset_binary(sat_sample) : MUTE_CODE;
            clip_d   = sat_clip;
            locked_d = det_locked;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gate_q    <= '0;
            ecnt_q    <= '0;
            cnt_q     <= '0;
            cap_vld_q <= 1'b0;
            diff_q    <= '0;
            st1_vld_q <= 1'b0;
            dat_q     <= MUTE_CODE;
            vld_q     <= 1'b0;
            clip_q    <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            ecnt_q    <= ecnt_d;
            cnt_q     <= cnt_d;
            cap_vld_q <= cap_vld_d;
            if (cap_vld_q) begin
                diff_q <= diff_d;
            end
            st1_vld_q <= st1_vld_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            clip_q    <= clip_d;
            locked_q  <= locked_d;
        end
    end

    assign o_dat     = dat_q;
    assign o_dat_vld = vld_q;
    assign o_clip    = clip_q;
    assign o_locked  = locked_q;

endmodule

// File: tb/tb_fm_demodulator.sv
// -----------------------------------------------------------------------------
// tb_fm_demodulator
// Four demodulator instances with different parameter sets are driven by
// independent random square waves (random period per segment, plus constant
// levels). A behavioural model bins every input rising edge into the window
// in which the synchronised edge lands, then derives the expected sample,
// clip flag and lock status per window from plain arithmetic.
//   A: gate 100,  centre 20,  tol 4,   shift 0, 16-bit counter
//   B: gate 100,  centre 20,  tol 8,   shift 1, 16-bit counter
//   C: gate 1000, centre 100, tol 511, shift 0, 16-bit counter
//   D: gate 100,  centre 20,  tol 8,   shift 0, 4-bit counter (saturates)
// -----------------------------------------------------------------------------
module tb_fm_demodulator;

    localparam int NI           = 4;
    localparam int LOCK_WINDOWS = 2;
    localparam int SYNC_DELAY   = 2;   // input edge -> counted rise, in cycles

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NI-1:0]   rf  = '0;
    logic [NI-1:0][7:0] dat;
    logic [NI-1:0]   vld;
    logic [NI-1:0]   clip;
    logic [NI-1:0]   locked;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // behavioural model state
    int win_cnt  [NI][4];
    int streak   [NI];
    bit locked_m [NI];
    bit last_d   [NI];
    int period   [NI];
    int ph       [NI];
    int seg_left [NI];

    always #5 clk = ~clk;

    fm_demodulator #(.GATE_CYCLES(100), .CENTER_COUNT(20), .SHIFT(0), .CNT_W(16),
                     .LOCK_TOL(4), .LOCK_WINDOWS(LOCK_WINDOWS)) u_a (
        .i_clk(clk), .i_rst(rst), .i_rf(rf[0]), .o_dat(dat[0]),
        .o_dat_vld(vld[0]), .o_clip(clip[0]), .o_locked(locked[0]));

    fm_demodulator #(.GATE_CYCLES(100), .CENTER_COUNT(20), .SHIFT(1), .CNT_W(16),
                     .LOCK_TOL(8), .LOCK_WINDOWS(LOCK_WINDOWS)) u_b (
        .i_clk(clk), .i_rst(rst), .i_rf(rf[1]), .o_dat(dat[1]),
        .o_dat_vld(vld[1]), .o_clip(clip[1]), .o_locked(locked[1]));

    fm_demodulator #(.GATE_CYCLES(1000), .CENTER_COUNT(100), .SHIFT(0), .CNT_W(16),
                     .LOCK_TOL(511), .LOCK_WINDOWS(LOCK_WINDOWS)) u_c (
        .i_clk(clk), .i_rst(rst), .i_rf(rf[2]), .o_dat(dat[2]),
        .o_dat_vld(vld[2]), .o_clip(clip[2]), .o_locked(locked[2]));

    fm_demodulator #(.GATE_CYCLES(100), .CENTER_COUNT(20), .SHIFT(0), .CNT_W(4),
                     .LOCK_TOL(8), .LOCK_WINDOWS(LOCK_WINDOWS)) u_d (
        .i_clk(clk), .i_rst(rst), .i_rf(rf[3]), .o_dat(dat[3]),
        .o_dat_vld(vld[3]), .o_clip(clip[3]), .o_locked(locked[3]));

    // ---------------- per-instance configuration ----------------
    function automatic string iname(input int k);
        case (k)
            0: return "A";
            1: return "B";
            2: return "C";
            default: return "D";
        endcase
    endfunction

    function automatic int p_gate(input int k);
        return (k == 2) ? 1000 : 100;
    endfunction

    function automatic int p_center(input int k);
        return (k == 2) ? 100 : 20;
    endfunction

    function automatic int p_tol(input int k);
        case (k)
            0: return 4;
            2: return 511;
            default: return 8;
        endcase
    endfunction

    function automatic int p_shift(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int p_cntw(input int k);
        return (k == 3) ? 4 : 16;
    endfunction

    function automatic int p_nominal(input int k);
        return (k == 2) ? 10 : 5;
    endfunction

    function automatic int p_nchoice(input int k);
        return (k == 2) ? 6 : 5;
    endfunction

    // 0 = constant low, 1 = constant high, otherwise square-wave period
    function automatic int p_pick(input int k, input int r);
        case (k)
            0: return (r == 0) ? 5 : (r == 1) ? 4 : (r == 2) ? 6 : (r == 3) ? 7 : 0;
            1: return (r == 0) ? 5 : (r == 1) ? 4 : (r == 2) ? 6 : (r == 3) ? 3 : 0;
            2: return (r == 0) ? 10 : (r == 1) ? 2 : (r == 2) ? 8 : (r == 3) ? 12 :
                      (r == 4) ? 0 : 1;
            default: return (r == 0) ? 5 : (r == 1) ? 2 : (r == 2) ? 7 : (r == 3) ? 8 : 10;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Compare all instances for the current cycle (called at the negedge).
    task automatic check_cycle();
        int g, j, n, sat_max, diff, s, sc, dat_e;
        bit exp_v, inr, clip_e;
        for (int k = 0; k < NI; k++) begin
            g     = p_gate(k);
            exp_v = 1'b0;
            // window j closes at cycle (j+1)*g-1; its strobe is 3 cycles later
            if (cyc >= g + 2 && ((cyc - 2) % g) == 0) begin
                exp_v   = 1'b1;
                j       = (cyc - 2) / g - 1;
                n       = win_cnt[k][j % 4];
                win_cnt[k][j % 4] = 0;
                sat_max = (1 << p_cntw(k)) - 1;
                if (n > sat_max) n = sat_max;
                diff = n - p_center(k);
                inr  = (diff <= p_tol(k)) && (diff >= -p_tol(k));
                // a streak of windows disagreeing with the current lock state
                if (locked_m[k] ? !inr : inr) streak[k]++;
                else                          streak[k] = 0;
                if (streak[k] == LOCK_WINDOWS) begin
                    locked_m[k] = !locked_m[k];
                    streak[k]   = 0;
                end
                s      = diff >>> p_shift(k);
                clip_e = (s > 127) || (s < -128);
                sc     = (s > 127) ? 127 : (s < -128) ? -128 : s;
                dat_e  = locked_m[k] ? sc + 128 : 128;
                chk($sformatf("%s.dat w%0d", iname(k), j), int'(dat[k]), dat_e);
                chk($sformatf("%s.clip w%0d", iname(k), j), int'(clip[k]), int'(clip_e));
                $display("[TB] %s window %0d edges=%0d diff=%0d dat=%02h clip=%0d locked=%0d",
                         iname(k), j, n, diff, dat[k], clip[k], locked[k]);
            end
            chk($sformatf("%s.vld", iname(k)), int'(vld[k]), int'(exp_v));
            chk($sformatf("%s.locked", iname(k)), int'(locked[k]), int'(locked_m[k]));
        end
    endtask

    // Drive the next input level for every instance and log its edges.
    task automatic drive_cycle(input bit nominal);
        bit d;
        int w;
        for (int k = 0; k < NI; k++) begin
            if (nominal) begin
                period[k] = p_nominal(k);
            end else begin
                if (seg_left[k] == 0) begin
                    period[k]   = p_pick(k, int'($urandom_range(0, p_nchoice(k) - 1)));
                    seg_left[k] = p_gate(k) * int'($urandom_range(1, 3))
                                  + int'($urandom_range(0, 60));
                    ph[k]       = 0;
                end
                seg_left[k]--;
            end
            if (period[k] == 0) begin
                d = 1'b0;
            end else if (period[k] == 1) begin
                d = 1'b1;
            end else begin
                d     = (ph[k] < period[k] / 2);
                ph[k] = (ph[k] + 1) % period[k];
            end
            if (d && !last_d[k]) begin
                w = (cyc + SYNC_DELAY) / p_gate(k);
                win_cnt[k][w % 4]++;
            end
            last_d[k] = d;
            rf[k]     = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rf  = '0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s.rst dat", iname(k)), int'(dat[k]), 128);
            chk($sformatf("%s.rst vld", iname(k)), int'(vld[k]), 0);
            chk($sformatf("%s.rst clip", iname(k)), int'(clip[k]), 0);
            chk($sformatf("%s.rst locked", iname(k)), int'(locked[k]), 0);
            streak[k]   = 0;
            locked_m[k] = 1'b0;
            last_d[k]   = 1'b0;
            ph[k]       = 0;
            seg_left[k] = 0;
            period[k]   = p_nominal(k);
            for (int b = 0; b < 4; b++) win_cnt[k][b] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        check_cycle();
        drive_cycle(1'b1);
        cyc++;
    endtask

    task automatic run(input int n, input bit nominal);
        repeat (n) begin
            @(negedge clk);
            check_cycle();
            drive_cycle(nominal);
            cyc++;
        end
    endtask

    initial begin
        do_reset();
        run(3500, 1'b1);    // lock every instance on its centre frequency
        run(11000, 1'b0);   // random frequency / level segments
        run(1049, 1'b1);    // relock, then reset mid-window while locked
        do_reset();
        run(3500, 1'b1);
        run(12000, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
